// File: rtl/dmem_copy_engine.sv
// Block-copy engine that masters the single-port data memory while busy.
// Optional `COPY_FILL_EN adds a one-cycle-per-word fill mode (fill, fill_value).
module dmem_copy_engine #(
    parameter int LENW  = 16,
    parameter int Dbits = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [31:2]      src_addr,
    input  logic [31:2]      dst_addr,
    input  logic [LENW-1:0]  len,
`ifdef COPY_FILL_EN
    input  logic             fill,
    input  logic [Dbits-1:0] fill_value,
`endif
    output logic             busy,
    output logic             done,
    output logic [LENW-1:0]  remaining,
    output logic             mem_wr,
    output logic [31:2]      mem_addr,
    output logic [Dbits-1:0] mem_writedata,
    input  logic [Dbits-1:0] mem_readdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} state_t;

    state_t          state;
    state_t          state_next;
    logic [31:2]     sp;
    logic [31:2]     dp;
    logic [Dbits-1:0] data;
    logic            fill_mode;
    logic            fill_req;
    logic [LENW-1:0] rem_dec;

`ifdef COPY_FILL_EN
    assign fill_req = fill;
`else
    assign fill_req = 1'b0;
`endif

    assign rem_dec = remaining - LENW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0)    state_next = FINISH;
                    else if (fill_req) state_next = WRITE;
                    else               state_next = READ;
                end
            end
            READ:   state_next = WRITE;
            WRITE: begin
                if (rem_dec == '0)  state_next = FINISH;
                else if (fill_mode) state_next = WRITE;
                else                state_next = READ;
            end
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pointers, count and data word; only IDLE with start reloads them, so a
    // start pulse while busy leaves the transfer untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp        <= '0;
            dp        <= '0;
            remaining <= '0;
            data      <= '0;
            fill_mode <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sp        <= src_addr;
                        dp        <= dst_addr;
                        remaining <= len;
                        fill_mode <= fill_req;
`ifdef COPY_FILL_EN
                        if (fill) data <= fill_value;
`endif
                    end
                end
                READ: data <= mem_readdata;
                WRITE: begin
                    sp        <= sp + 30'd1;
                    dp        <= dp + 30'd1;
                    remaining <= rem_dec;
                end
                default: ;
            endcase
        end
    end

    assign busy          = (state != IDLE);
    assign done          = (state == FINISH);
    assign mem_wr        = (state == WRITE);
    assign mem_writedata = data;

    always_comb begin
        mem_addr = '0;
        case (state)
            READ:    mem_addr = sp;
            WRITE:   mem_addr = dp;
            default: mem_addr = '0;
        endcase
    end

endmodule

// File: doc/dmem_copy_engine.md
Name: dmem_copy_engine

Overview:
- Initiator-side block driving the single-port data memory interface (mem_wr, mem_addr[31:2], mem_writedata, mem_readdata).
- Copies a block of 32-bit words from a source word address to a destination word address.
- The CPU or a test harness starts it with a one-cycle start pulse; it reports progress through busy/done.
- Sits beside the CPU in front of the data memory; a top-level mux selects the engine as the memory master while busy=1.

Parameters:
- LENW, 16, width of the word-count input and the remaining-count register.
- Dbits, 32, data word width; must match the memory data width.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- src_addr  input  [31:2]  source word address.
- dst_addr  input  [31:2]  destination word address.
- len  input  [LENW-1:0]  number of words to copy.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse at completion.
- remaining  output  [LENW-1:0]  words still to copy.
- mem_wr  output  1  memory write enable.
- mem_addr  output  [31:2]  memory word address.
- mem_writedata  output  [31:0]  memory write data.
- mem_readdata  input  [31:0]  memory read data; combinational from mem_addr.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; busy=0, done=0, mem_wr=0, mem_addr=0, mem_writedata=0, remaining=0. Reset mid-copy abandons the transfer; no further write is issued.
- States: IDLE, READ, WRITE, FINISH.
- IDLE:
  - On start=1, latch src, dst and len into internal registers (sp, dp, remaining).
  - If len!=0, go to READ; if len=0, go to FINISH with no memory access.
  - While in IDLE, mem_wr=0.
- READ:
  - mem_addr=sp, mem_wr=0.
  - At the clock edge, capture mem_readdata into the data register and go to WRITE.
- WRITE:
  - mem_addr=dp, mem_writedata=data register, mem_wr=1 for exactly this cycle.
  - At the clock edge: sp+=1, dp+=1, remaining-=1.
  - If the new remaining is 0, go to FINISH; otherwise go to READ.
- FINISH: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- busy=1 in READ, WRITE and FINISH.
- Throughput: 2 cycles per word. Latency from start to the done pulse is 2*len+1 cycles after the start edge; for len=0 it is 1 cycle.
- start while busy is ignored and has no side effects.
- Address arithmetic is modulo 2^30 words: 0x3FFFFFFF+1 wraps to 0.
- Copy is strictly ascending. Overlapping regions with dst>src propagate already-copied data; this is defined behaviour, not an error.
- mem_addr, mem_wr and mem_writedata are registered-state driven only; there is no combinational path from start to mem_wr.

Optional Feature:
- Macro COPY_FILL_EN.
- When defined, add ports `fill` (input, 1) and `fill_value` (input, [31:0]), both latched on start.
  - fill=1: skip READ entirely; WRITE writes fill_value to dp..dp+len-1 at 1 cycle per word. Done arrives len+1 cycles after start.
  - fill=0: normal copy.
- When undefined, neither port exists and the engine is copy-only.

Test Plan:
- Preload mem[4..7]=0x11,0x22,0x33,0x44; start src=4 dst=20 len=4 -> mem[20..23]=0x11..0x44; exactly 4 mem_wr pulses; done pulses at cycle 9 after start; mem[4..7] unchanged.
- start with len=0 -> done at cycle 1; mem_wr never asserted; busy high for exactly 1 cycle.
- Assert start again mid-transfer with src=0 dst=0 len=1 -> ignored; the original copy completes unchanged.
- Assert reset_n=0 after 2 words of a len=8 copy -> mem_wr drops immediately; only 2 destination words modified; busy=0, remaining=0.
- src=0x3FFFFFFF dst=0x10 len=2 -> reads 0x3FFFFFFF then 0x0 (wrap); writes 0x10 and 0x11.
- With COPY_FILL_EN: fill=1 fill_value=0xDEADBEEF dst=8 len=3 -> mem[8..10]=0xDEADBEEF; mem_wr high 3 consecutive cycles; done at cycle 4.
